// File: rtl/lbm_pkg.sv
`default_nettype none
// ============================================================================
//  lbm_pkg
//  Shared sizes and types for the lattice BRAM arbiter.
//  Revision: 1.0
// ============================================================================
package lbm_pkg;
    localparam int BRAM_DEPTH = 31570;
    localparam int ADDR_W     = $clog2(BRAM_DEPTH);
    localparam int N_DIR      = 9;

    localparam logic [ADDR_W-1:0] C_ADDR_LIMIT = ADDR_W'(BRAM_DEPTH);

    typedef logic [N_DIR-1:0][7:0]        dir_vec_t;
    typedef logic [N_DIR-1:0][ADDR_W-1:0] addr_vec_t;

    typedef enum logic {
        OWN_ENG  = 1'b0,
        OWN_DISP = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   err;
    } rd_tag_t;
endpackage
`default_nettype wire

// File: rtl/lattice_bram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  lattice_bram_arbiter_if
//  Engine, display and BRAM-side signals of the lattice BRAM arbiter.
//  Revision: 1.0
// ============================================================================
interface lattice_bram_arbiter_if;
    import lbm_pkg::*;

    logic              eng_req_in;
    logic              eng_we_in;
    addr_vec_t         eng_addr_in;
    dir_vec_t          eng_data_in;
    logic              eng_lock_in;
    logic              eng_gnt_out;
    logic              eng_rvalid_out;
    dir_vec_t          eng_rdata_out;
    logic              disp_req_in;
    logic [ADDR_W-1:0] disp_addr_in;
    logic              disp_gnt_out;
    logic              disp_rvalid_out;
    dir_vec_t          disp_rdata_out;
    addr_vec_t         bram_addr_out;
    logic              bram_we_out;
    dir_vec_t          bram_data_out;
    dir_vec_t          bram_data_in;
    logic              err_out;

    modport slave (
        input  eng_req_in, eng_we_in, eng_addr_in, eng_data_in, eng_lock_in,
        input  disp_req_in, disp_addr_in, bram_data_in,
        output eng_gnt_out, eng_rvalid_out, eng_rdata_out,
        output disp_gnt_out, disp_rvalid_out, disp_rdata_out,
        output bram_addr_out, bram_we_out, bram_data_out, err_out
    );

    modport master (
        output eng_req_in, eng_we_in, eng_addr_in, eng_data_in, eng_lock_in,
        output disp_req_in, disp_addr_in, bram_data_in,
        input  eng_gnt_out, eng_rvalid_out, eng_rdata_out,
        input  disp_gnt_out, disp_rvalid_out, disp_rdata_out,
        input  bram_addr_out, bram_we_out, bram_data_out, err_out
    );
endinterface
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  rd_tag_pipe
//  Shift register carrying {valid, owner, err} alongside BRAM reads.
//  Revision: 1.0
// ============================================================================
module rd_tag_pipe
    import lbm_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire logic clk_in,
    input  wire logic rst_in,
    input  rd_tag_t   tag_in,
    output rd_tag_t   tag_pre_out,
    output rd_tag_t   tag_out
);
    rd_tag_t [DEPTH-1:0] stage_q;
    rd_tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // The pre-tap lines up with BRAM data one cycle before it is registered out.
    assign tag_pre_out = stage_q[DEPTH-2];
    assign tag_out     = stage_q[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/lattice_bram_arbiter.sv
`default_nettype none
// ============================================================================
//  lattice_bram_arbiter
//  Shares the 9-bank lattice BRAM between the LBM engine and display readout.
//  Revision: 1.0
// ============================================================================
module lattice_bram_arbiter
    import lbm_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int MAX_STARVE   = 64
) (
    input  wire logic              clk_in,
    input  wire logic              rst_in,
    lattice_bram_arbiter_if.slave  bus
);
    localparam int              C_CNT_W = $clog2(MAX_STARVE + 1);
    localparam logic [C_CNT_W-1:0] C_STARVE_MAX = C_CNT_W'(MAX_STARVE);

    logic [C_CNT_W-1:0] starve_q, starve_d;
    addr_vec_t          addr_q, addr_d;
    dir_vec_t           wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               err_q, err_d;
    dir_vec_t           eng_rdata_q, eng_rdata_d;
    dir_vec_t           disp_rdata_q, disp_rdata_d;

    logic    w_eng_gnt, w_disp_gnt, w_oor_eng, w_oor_disp, w_oor;
    rd_tag_t w_tag_in, w_tag_pre, w_tag_out;

    always_comb begin
        w_oor_eng = 1'b0;
        for (int i = 0; i < N_DIR; i++) begin
            if (bus.eng_addr_in[i] >= C_ADDR_LIMIT) w_oor_eng = 1'b1;
        end
    end
    assign w_oor_disp = (bus.disp_addr_in >= C_ADDR_LIMIT);

    // Display wins only when the engine is idle or it has waited MAX_STARVE cycles.
    always_comb begin
        w_eng_gnt  = 1'b0;
        w_disp_gnt = 1'b0;
        if (!rst_in) begin
            if (bus.disp_req_in && !bus.eng_lock_in &&
                (!bus.eng_req_in || starve_q == C_STARVE_MAX)) begin
                w_disp_gnt = 1'b1;
            end else if (bus.eng_req_in) begin
                w_eng_gnt = 1'b1;
            end
        end
    end

    assign w_oor = (w_eng_gnt && w_oor_eng) || (w_disp_gnt && w_oor_disp);

    always_comb begin
        starve_d = starve_q;
        if (!bus.disp_req_in || bus.eng_lock_in || w_disp_gnt) begin
            starve_d = '0;
        end else if (starve_q != C_STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (w_eng_gnt) begin
            addr_d = bus.eng_addr_in;
            we_d   = bus.eng_we_in && !w_oor_eng;
            if (bus.eng_we_in) wdata_d = bus.eng_data_in;
        end else if (w_disp_gnt) begin
            for (int i = 0; i < N_DIR; i++) begin
                addr_d[i] = bus.disp_addr_in;
            end
        end
        err_d = err_q || w_oor;
    end

    always_comb begin
        w_tag_in.valid = (w_eng_gnt && !bus.eng_we_in) || w_disp_gnt;
        w_tag_in.owner = w_disp_gnt ? OWN_DISP : OWN_ENG;
        w_tag_in.err   = w_oor;
    end

    rd_tag_pipe #(
        .DEPTH (1 + READ_LATENCY)
    ) u_rd_tag_pipe (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .tag_in      (w_tag_in),
        .tag_pre_out (w_tag_pre),
        .tag_out     (w_tag_out)
    );

    always_comb begin
        eng_rdata_d  = eng_rdata_q;
        disp_rdata_d = disp_rdata_q;
        if (w_tag_pre.valid) begin
            if (w_tag_pre.owner == OWN_ENG) begin
                eng_rdata_d = w_tag_pre.err ? '0 : bus.bram_data_in;
            end else begin
                disp_rdata_d = w_tag_pre.err ? '0 : bus.bram_data_in;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            eng_rdata_q  <= '0;
            disp_rdata_q <= '0;
        end else begin
            starve_q     <= starve_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            err_q        <= err_d;
            eng_rdata_q  <= eng_rdata_d;
            disp_rdata_q <= disp_rdata_d;
        end
    end

    assign bus.eng_gnt_out     = w_eng_gnt;
    assign bus.disp_gnt_out    = w_disp_gnt;
    assign bus.bram_addr_out   = addr_q;
    assign bus.bram_we_out     = we_q;
    assign bus.bram_data_out   = wdata_q;
    assign bus.err_out         = err_q;
    assign bus.eng_rvalid_out  = w_tag_out.valid && (w_tag_out.owner == OWN_ENG);
    assign bus.disp_rvalid_out = w_tag_out.valid && (w_tag_out.owner == OWN_DISP);
    assign bus.eng_rdata_out   = eng_rdata_q;
    assign bus.disp_rdata_out  = disp_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_lattice_bram_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_lattice_bram_arbiter
//  Directed stimulus with a queue-based reference model checked every cycle.
//  Revision: 1.0
// ============================================================================
module tb_lattice_bram_arbiter;
    import lbm_pkg::*;

    localparam int MAX_STARVE = 64;
    localparam int RD_LAT     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   chk_en  = 1'b0;

    always #5 clk = ~clk;

    lattice_bram_arbiter_if bus();

    lattice_bram_arbiter #(
        .READ_LATENCY (RD_LAT),
        .MAX_STARVE   (MAX_STARVE)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    // BRAM environment: write-first, data appears the cycle after the address.
    logic [7:0] mem [N_DIR][32768];
    initial begin
        for (int b = 0; b < N_DIR; b++)
            for (int a = 0; a < 32768; a++)
                mem[b][a] = 8'(a & 'h7F);
    end
    always @(posedge clk) begin : p_bram
        dir_vec_t rd;
        if (bus.bram_we_out)
            for (int i = 0; i < N_DIR; i++) mem[i][bus.bram_addr_out[i]] = bus.bram_data_out[i];
        for (int i = 0; i < N_DIR; i++) rd[i] = mem[i][bus.bram_addr_out[i]];
        bus.bram_data_in <= rd;
    end

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        bit       disp;
        dir_vec_t data;
    } ret_t;

    ret_t       rq[$];
    logic [7:0] ref_mem [int];
    int         m_starve = 0;
    addr_vec_t  m_addr   = '0;
    bit         m_we     = 1'b0;
    dir_vec_t   m_wdata  = '0;
    bit         m_err    = 1'b0;
    bit         m_clr    = 1'b0;
    dir_vec_t   m_eng_rd  = '0;
    dir_vec_t   m_disp_rd = '0;

    function automatic logic [7:0] ref_rd(int bank, logic [ADDR_W-1:0] a);
        int k = bank * 32768 + int'(a);
        if (ref_mem.exists(k)) return ref_mem[k];
        return {1'b0, a[6:0]};
    endfunction

    function automatic void exp_grants(output bit ge, output bit gd);
        gd = !rst && bus.disp_req_in && !bus.eng_lock_in &&
             (!bus.eng_req_in || m_starve == MAX_STARVE);
        ge = !rst && !gd && bus.eng_req_in;
    endfunction

    always @(posedge clk) begin : p_model
        bit   ge, gd, oor;
        ret_t r;
        exp_grants(ge, gd);
        m_clr = rst;
        if (rst) begin
            m_starve = 0; m_addr = '0; m_we = 0; m_wdata = '0; m_err = 0;
            rq.delete();
        end else begin
            oor = 0;
            if (ge) for (int i = 0; i < N_DIR; i++) if (int'(bus.eng_addr_in[i]) >= BRAM_DEPTH) oor = 1;
            if (gd && int'(bus.disp_addr_in) >= BRAM_DEPTH) oor = 1;
            if (gd || !bus.disp_req_in || bus.eng_lock_in) m_starve = 0;
            else if (m_starve < MAX_STARVE) m_starve++;
            m_we = 0;
            if (ge) begin
                m_addr = bus.eng_addr_in;
                if (bus.eng_we_in) begin
                    m_wdata = bus.eng_data_in;
                    if (!oor) begin
                        m_we = 1;
                        for (int i = 0; i < N_DIR; i++)
                            ref_mem[i * 32768 + int'(bus.eng_addr_in[i])] = bus.eng_data_in[i];
                    end
                end else begin
                    r.due = cyc + 1 + RD_LAT; r.disp = 0;
                    for (int i = 0; i < N_DIR; i++) r.data[i] = oor ? 8'h00 : ref_rd(i, bus.eng_addr_in[i]);
                    rq.push_back(r);
                end
            end else if (gd) begin
                r.due = cyc + 1 + RD_LAT; r.disp = 1;
                for (int i = 0; i < N_DIR; i++) begin
                    m_addr[i] = bus.disp_addr_in;
                    r.data[i] = oor ? 8'h00 : ref_rd(i, bus.disp_addr_in);
                end
                rq.push_back(r);
            end
            if (oor) m_err = 1;
        end
        cyc++;
    end

    always @(negedge clk) begin : p_compare
        bit ge, gd, erv, drv;
        erv = 0; drv = 0;
        if (m_clr) begin m_eng_rd = '0; m_disp_rd = '0; end
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].disp) begin drv = 1; m_disp_rd = rq[0].data; end
            else            begin erv = 1; m_eng_rd  = rq[0].data; end
            void'(rq.pop_front());
        end
        if (chk_en) begin
            exp_grants(ge, gd);
            chk("eng_gnt",     bus.eng_gnt_out,     ge);
            chk("disp_gnt",    bus.disp_gnt_out,    gd);
            chk("bram_addr",   bus.bram_addr_out,   m_addr);
            chk("bram_we",     bus.bram_we_out,     m_we);
            chk("bram_data",   bus.bram_data_out,   m_wdata);
            chk("err",         bus.err_out,         m_err);
            chk("eng_rvalid",  bus.eng_rvalid_out,  erv);
            chk("eng_rdata",   bus.eng_rdata_out,   m_eng_rd);
            chk("disp_rvalid", bus.disp_rvalid_out, drv);
            chk("disp_rdata",  bus.disp_rdata_out,  m_disp_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : p_drive
        int wait_k, n, n_we, rv_k, n_erv, n_drv;
        bus.eng_req_in = 0; bus.eng_we_in = 0; bus.eng_addr_in = '0; bus.eng_data_in = '0;
        bus.eng_lock_in = 0; bus.disp_req_in = 0; bus.disp_addr_in = '0;
        rst = 1;
        step(); chk_en = 1; step();
        rst = 0;
        #3;
        chk("reset_err", bus.err_out, 1'b0);
        chk("reset_rdata", bus.eng_rdata_out, 72'h0);
        step();

        // Priority and starvation
        bus.eng_req_in = 1; bus.eng_we_in = 0; bus.eng_addr_in = {9{15'd5}};
        bus.disp_req_in = 1; bus.disp_addr_in = 15'd7;
        #3;
        chk("prio_eng_gnt",  bus.eng_gnt_out,  1'b1);
        chk("prio_disp_gnt", bus.disp_gnt_out, 1'b0);
        wait_k = 0;
        for (int k = 1; k <= 100; k++) begin
            if (bus.disp_gnt_out) begin wait_k = k; break; end
            step(); #3;
        end
        chk("starve_wait_cycle", 32'(wait_k), 32'd65);
        step(); #3;
        chk("post_grant_disp_gnt", bus.disp_gnt_out, 1'b0);
        chk("post_grant_eng_gnt",  bus.eng_gnt_out,  1'b1);
        bus.disp_req_in = 0; bus.eng_req_in = 0;
        repeat (4) step();

        // Lock blocks the display
        bus.eng_lock_in = 1; bus.disp_req_in = 1; bus.disp_addr_in = 15'd9;
        n = 0;
        repeat (200) begin #3; if (bus.disp_gnt_out) n++; step(); end
        chk("lock_disp_grants", 32'(n), 32'd0);
        bus.eng_lock_in = 0;
        #3;
        chk("unlock_disp_gnt", bus.disp_gnt_out, 1'b1);
        step(); bus.disp_req_in = 0;
        repeat (4) step();

        // Pipelined routing: engine addr 5 / display addr 7 alternating
        n_erv = 0; n_drv = 0;
        for (int k = 0; k < 14; k++) begin
            if (k < 10 && k % 2 == 0) begin
                bus.eng_req_in = 1; bus.eng_we_in = 0; bus.eng_addr_in = {9{15'd5}}; bus.disp_req_in = 0;
            end else if (k < 10) begin
                bus.eng_req_in = 0; bus.disp_req_in = 1; bus.disp_addr_in = 15'd7;
            end else begin
                bus.eng_req_in = 0; bus.disp_req_in = 0;
            end
            #3;
            if (bus.eng_rvalid_out)  n_erv++;
            if (bus.disp_rvalid_out) n_drv++;
            step();
        end
        chk("route_eng_pulses",  32'(n_erv), 32'd5);
        chk("route_disp_pulses", 32'(n_drv), 32'd5);
        chk("route_eng_data",  bus.eng_rdata_out,  {9{8'h05}});
        chk("route_disp_data", bus.disp_rdata_out, {9{8'h07}});

        // Write then read the same address on consecutive cycles
        bus.eng_req_in = 1; bus.eng_we_in = 1; bus.eng_addr_in = {9{15'd100}}; bus.eng_data_in = {9{8'h0A}};
        step();
        bus.eng_we_in = 0;
        n_we = 0; rv_k = 0;
        #3; if (bus.bram_we_out) n_we++;
        step(); bus.eng_req_in = 0;
        for (int k = 1; k <= 6; k++) begin
            #3;
            if (bus.bram_we_out) n_we++;
            if (bus.eng_rvalid_out && rv_k == 0) rv_k = k;
            step();
        end
        chk("raw_we_cycles", 32'(n_we), 32'd1);
        chk("raw_rvalid_latency", 32'(rv_k), 32'd3);
        chk("raw_data", bus.eng_rdata_out, {9{8'h0A}});

        // Out-of-range write on bank 3, then display read out of range
        bus.eng_req_in = 1; bus.eng_we_in = 1; bus.eng_addr_in = {9{15'd200}};
        bus.eng_addr_in[3] = 15'd31570; bus.eng_data_in = {9{8'h55}};
        step(); bus.eng_req_in = 0; bus.eng_we_in = 0;
        n_we = 0;
        repeat (4) begin #3; if (bus.bram_we_out) n_we++; step(); end
        chk("oor_we_cycles", 32'(n_we), 32'd0);
        chk("oor_err", bus.err_out, 1'b1);
        bus.disp_req_in = 1; bus.disp_addr_in = 15'd31570;
        step(); bus.disp_req_in = 0;
        rv_k = 0;
        for (int k = 1; k <= 6; k++) begin
            #3;
            if (bus.disp_rvalid_out && rv_k == 0) rv_k = k;
            step();
        end
        chk("oor_disp_latency", 32'(rv_k), 32'd3);
        chk("oor_disp_data", bus.disp_rdata_out, 72'h0);
        bus.eng_req_in = 1; bus.eng_addr_in = {9{15'd200}};
        step(); bus.eng_req_in = 0;
        repeat (4) step();
        chk("oor_write_suppressed", bus.eng_rdata_out, {9{8'h48}});
        chk("oor_err_sticky", bus.err_out, 1'b1);

        // Reset while a read is in flight
        bus.eng_req_in = 1; bus.eng_addr_in = {9{15'd5}};
        step(); bus.eng_req_in = 0; rst = 1;
        step(); rst = 0;
        #3;
        chk("rst_err",        bus.err_out,        1'b0);
        chk("rst_bram_addr",  bus.bram_addr_out,  135'h0);
        chk("rst_eng_rdata",  bus.eng_rdata_out,  72'h0);
        chk("rst_disp_rdata", bus.disp_rdata_out, 72'h0);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (bus.eng_rvalid_out) n++;
            step(); #3;
        end
        chk("rst_no_rvalid", 32'(n), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
